// File: rtl/hps_pixel_fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hps_pixel_fetch_pkg
// Brief    : Shared types and constants for the HPS pixel fetch path.
// Revision : 1.0 - initial release
// ============================================================================
package hps_pixel_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } fetch_state_t;

    localparam int PIX_PER_WORD = 4;
    localparam int IMG_W        = 160;
    localparam int IMG_H        = 120;
    localparam int IMG_PIXELS   = IMG_W * IMG_H;
    localparam int HPS_WORD_W   = 32;
    localparam int WORD_ADDR_W  = 15;

    // Little-endian lane select: pixel k lives in bits [8k+7:8k].
    function automatic logic [7:0] pick_byte(input logic [HPS_WORD_W-1:0] word,
                                             input logic [1:0]            lane);
        return word[lane*8 +: 8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/hps_pixel_fetch_sync_2ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Single-bit flip-flop synchroniser with configurable depth.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    generate
        if (STAGES == 1) begin : g_single
            // One-stage capture of the asynchronous input.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) sync_q <= '0;
                else         sync_q <= d_i;
            end
        end else begin : g_chain
            // Shift the asynchronous input through the flop chain.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) sync_q <= '0;
                else         sync_q <= {sync_q[STAGES-2:0], d_i};
            end
        end
    endgenerate

    assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/hps_pixel_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hps_pixel_fetch
// Brief    : Pixel fetch with one-word cache; misses go to the HPS over a
//            4-phase req/ack handshake with a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module hps_pixel_fetch
    import hps_pixel_fetch_pkg::*;
#(
    parameter int PIX_ADDR_W     = 15,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                   clk_50MHz,
    input  logic                   vga_reset,
    input  logic                   pix_req_i,
    input  logic [PIX_ADDR_W-1:0]  pix_addr_i,
    input  logic                   flush_i,
    output logic                   pix_valid_o,
    output logic [7:0]             pix_data_o,
    output logic                   busy_o,
    output logic                   hps_req_o,
    output logic [WORD_ADDR_W-1:0] hps_addr_o,
    input  logic                   hps_ack_i,
    input  logic [HPS_WORD_W-1:0]  hps_data_i,
    output logic                   err_timeout_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    fetch_state_t           state_q;
    logic [HPS_WORD_W-1:0]  word_q;
    logic [WORD_ADDR_W-1:0] tag_q;
    logic                   valid_q;
    logic                   flushed_q;
    logic [1:0]             lane_q;
    logic [WORD_ADDR_W-1:0] hps_addr_q;
    logic                   hps_req_q;
    logic                   pix_valid_q;
    logic [7:0]             pix_data_q;
    logic                   err_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   w_ack_s;
    logic                   w_accept;
    logic                   w_hit;
    logic [WORD_ADDR_W-1:0] w_req_word;

    sync_2ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i  (clk_50MHz),
        .rst_ni (vga_reset),
        .d_i    (hps_ack_i),
        .q_o    (w_ack_s)
    );

    assign w_req_word = WORD_ADDR_W'(pix_addr_i[PIX_ADDR_W-1:2]);
    assign busy_o     = (state_q != ST_IDLE) | pix_valid_q;
    assign w_accept   = pix_req_i & ~busy_o;
    assign w_hit      = valid_q & (tag_q == w_req_word) & ~flush_i;

    // Fetch FSM: cache lookup, HPS handshake, timeout and pixel return.
    always_ff @(posedge clk_50MHz or negedge vga_reset) begin
        if (!vga_reset) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            tag_q       <= '0;
            valid_q     <= 1'b0;
            flushed_q   <= 1'b0;
            lane_q      <= '0;
            hps_addr_q  <= '0;
            hps_req_q   <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            pix_valid_q <= 1'b0;
            if (flush_i) valid_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_hit) begin
                            pix_valid_q <= 1'b1;
                            pix_data_q  <= pick_byte(word_q, pix_addr_i[1:0]);
                        end else begin
                            hps_addr_q <= w_req_word;
                            lane_q     <= pix_addr_i[1:0];
                            hps_req_q  <= 1'b1;
                            cnt_q      <= '0;
                            flushed_q  <= 1'b0;
                            state_q    <= ST_REQ;
                        end
                    end
                end

                ST_REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (flush_i) flushed_q <= 1'b1;
                    if (w_ack_s) begin
                        // A flush seen at any point of this fetch keeps the word uncached.
                        word_q      <= hps_data_i;
                        tag_q       <= hps_addr_q;
                        valid_q     <= ~(flushed_q | flush_i);
                        pix_valid_q <= 1'b1;
                        pix_data_q  <= pick_byte(hps_data_i, lane_q);
                        hps_req_q   <= 1'b0;
                        state_q     <= ST_REL;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        pix_valid_q <= 1'b1;
                        pix_data_q  <= 8'h00;
                        err_q       <= 1'b1;
                        hps_req_q   <= 1'b0;
                        state_q     <= ST_REL;
                    end
                end

                ST_REL: begin
                    if (flush_i) flushed_q <= 1'b1;
                    if (!w_ack_s) state_q <= ST_IDLE;
                end

                default: begin
                    hps_req_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign pix_valid_o   = pix_valid_q;
    assign pix_data_o    = pix_data_q;
    assign hps_req_o     = hps_req_q;
    assign hps_addr_o    = hps_addr_q;
    assign err_timeout_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_hps_pixel_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hps_pixel_fetch
// Brief    : Self-checking bench for hps_pixel_fetch with a cache/HPS model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hps_pixel_fetch;

    localparam int TO   = 16;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_req;
    logic [14:0] pix_addr;
    logic        flush;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        busy;
    logic        hps_req;
    logic [14:0] hps_addr;
    logic        hps_ack;
    logic [31:0] hps_data;
    logic        err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: HPS image store and a single cached word address.
    logic [31:0] mem [int];
    bit          m_valid;
    int          m_tag;
    bit          m_err;

    always #10 clk = ~clk;

    hps_pixel_fetch #(
        .PIX_ADDR_W     (15),
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk_50MHz     (clk),
        .vga_reset     (rst_n),
        .pix_req_i     (pix_req),
        .pix_addr_i    (pix_addr),
        .flush_i       (flush),
        .pix_valid_o   (pix_valid),
        .pix_data_o    (pix_data),
        .busy_o        (busy),
        .hps_req_o     (hps_req),
        .hps_addr_o    (hps_addr),
        .hps_ack_i     (hps_ack),
        .hps_data_i    (hps_data),
        .err_timeout_o (err_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int wa);
        if (!mem.exists(wa)) mem[wa] = $urandom;
        return mem[wa];
    endfunction

    function automatic logic [7:0] byte_of(input int pa);
        logic [31:0] w;
        w = word_of(pa / 4);
        return 8'((w >> (8 * (pa % 4))) & 32'hFF);
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle", {31'd0, busy}, 32'd0);
    endtask

    // One copier request; the model decides hit/miss and the expected byte.
    task automatic do_req(input int pa, input bit fl_acc, input bit fl_req,
                          input int dly, input bit no_ack, input bit poke);
        int wa;
        bit hit;
        int n;
        wa  = pa / 4;
        hit = m_valid && (m_tag == wa) && !fl_acc;
        if (fl_acc) m_valid = 1'b0;
        check_eq("busy_pre", {31'd0, busy}, 32'd0);
        pix_req  = 1'b1;
        pix_addr = 15'(pa);
        flush    = fl_acc;
        @(negedge clk);
        pix_req = 1'b0;
        flush   = 1'b0;
        if (hit) begin
            check_eq("hit_valid", {31'd0, pix_valid}, 32'd1);
            check_eq("hit_data", {24'd0, pix_data}, {24'd0, byte_of(pa)});
            check_eq("hit_noreq", {31'd0, hps_req}, 32'd0);
            if (poke) begin
                pix_req  = 1'b1;
                pix_addr = 15'(pa - 1);
            end
            @(negedge clk);
            pix_req = 1'b0;
            check_eq("hit_gap_valid", {31'd0, pix_valid}, 32'd0);
            check_eq("hit_gap_req", {31'd0, hps_req}, 32'd0);
            check_eq("hit_gap_busy", {31'd0, busy}, 32'd0);
        end else begin
            check_eq("miss_req", {31'd0, hps_req}, 32'd1);
            check_eq("miss_addr", {17'd0, hps_addr}, 32'(wa));
            if (no_ack) begin
                repeat (TO - 1) @(negedge clk);
                check_eq("to_wait_valid", {31'd0, pix_valid}, 32'd0);
                check_eq("to_wait_req", {31'd0, hps_req}, 32'd1);
                @(negedge clk);
                check_eq("to_valid", {31'd0, pix_valid}, 32'd1);
                check_eq("to_data", {24'd0, pix_data}, 32'd0);
                check_eq("to_req", {31'd0, hps_req}, 32'd0);
                m_err = 1'b1;
            end else begin
                for (int i = 1; i <= dly; i++) begin
                    if (fl_req && i == 1) flush = 1'b1;
                    @(negedge clk);
                    flush = 1'b0;
                end
                if (fl_req) m_valid = 1'b0;
                hps_ack  = 1'b1;
                hps_data = word_of(wa);
                n = 0;
                while (!pix_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check_eq("ack_latency", 32'(n), 32'(SYNC + 1));
                check_eq("miss_data", {24'd0, pix_data}, {24'd0, byte_of(pa)});
                check_eq("miss_req_drop", {31'd0, hps_req}, 32'd0);
                if (!fl_req) begin
                    m_valid = 1'b1;
                    m_tag   = wa;
                end
                hps_ack  = 1'b0;
                hps_data = $urandom;
            end
            wait_idle();
        end
        check_eq("err_timeout", {31'd0, err_timeout}, {31'd0, m_err});
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        pix_req  = 1'b0;
        pix_addr = '0;
        flush    = 1'b0;
        hps_ack  = 1'b0;
        hps_data = '0;
        m_valid  = 1'b0;
        m_tag    = 0;
        m_err    = 1'b0;

        // Reset: outputs stay zero even with hps_ack toggling.
        for (int i = 0; i < 5; i++) begin
            hps_ack = ~hps_ack;
            @(negedge clk);
        end
        check_eq("rst_valid", {31'd0, pix_valid}, 32'd0);
        check_eq("rst_data", {24'd0, pix_data}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_req", {31'd0, hps_req}, 32'd0);
        check_eq("rst_addr", {17'd0, hps_addr}, 32'd0);
        check_eq("rst_err", {31'd0, err_timeout}, 32'd0);
        hps_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Miss, hit with a dropped strobe, flush handling.
        mem[1] = 32'hDDCCBBAA;
        do_req(5, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        do_req(7, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        m_valid = 1'b0;
        do_req(4, 1'b0, 1'b0, 2, 1'b0, 1'b0);
        do_req(4, 1'b1, 1'b1, 3, 1'b0, 1'b0);
        do_req(4, 1'b0, 1'b0, 1, 1'b0, 1'b0);

        // Timeout then re-fetch of the same pixel.
        do_req(100, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        do_req(100, 1'b0, 1'b0, 2, 1'b0, 1'b0);
        do_req(101, 1'b0, 1'b0, 0, 1'b0, 1'b1);

        // Reset in the middle of a handshake.
        pix_req  = 1'b1;
        pix_addr = 15'd20;
        flush    = 1'b1;
        @(negedge clk);
        pix_req = 1'b0;
        flush   = 1'b0;
        check_eq("mid_req", {31'd0, hps_req}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_req", {31'd0, hps_req}, 32'd0);
        check_eq("mid_rst_valid", {31'd0, pix_valid}, 32'd0);
        check_eq("mid_rst_err", {31'd0, err_timeout}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        m_valid = 1'b0;
        m_err   = 1'b0;
        @(negedge clk);
        check_eq("post_rst_valid", {31'd0, pix_valid}, 32'd0);
        do_req(7, 1'b0, 1'b0, 2, 1'b0, 1'b0);

        // Randomized traffic clustered on a few words so hits are frequent.
        for (int t = 0; t < 80; t++) begin
            int pa;
            pa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 19199))
                                             : int'($urandom_range(0, 23));
            do_req(pa,
                   $urandom_range(0, 7) == 0,
                   $urandom_range(0, 5) == 0,
                   int'($urandom_range(1, 6)),
                   $urandom_range(0, 11) == 0,
                   $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hps_pixel_fetch.md
Name: hps_pixel_fetch

Overview:
- Fetch stage between the HPS-side image store and the ROM-to-framebuffer copier.
- The copier asks for one 8-bit pixel by linear pixel index. This block turns the request into a 32-bit word fetch from the HPS over a 4-phase req/ack handshake, then returns the addressed byte.
- A one-word cache means the three neighbouring pixels in the same word are served without another HPS transaction.

Parameters:
- PIX_ADDR_W, 15, width of pixel index (19200 pixels for a 160x120 image).
- TIMEOUT_CYCLES, 1024, clk_50MHz cycles allowed in REQ before the fetch is abandoned.
- SYNC_STAGES, 2, flip-flop stages on hps_ack.

Ports:
- clk_50MHz  in  1  system clock.
- vga_reset  in  1  asynchronous, active-low reset.
- pix_req  in  1  one-cycle request strobe from the copier.
- pix_addr  in  PIX_ADDR_W  pixel index, sampled with pix_req.
- flush  in  1  invalidates the cache (image reload or seletor change).
- pix_valid  out  1  one-cycle pulse; pix_data is valid in this cycle.
- pix_data  out  8  returned pixel.
- busy  out  1  high when a request would be ignored.
- hps_req  out  1  4-phase request to the HPS.
- hps_addr  out  15  word address = pix_addr>>2, zero-extended.
- hps_ack  in  1  HPS acknowledge; asynchronous to clk_50MHz.
- hps_data  in  32  HPS word; stable while hps_ack is high.
- err_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (async, vga_reset=0):
  - outputs: hps_req=0, pix_valid=0, pix_data=0, busy=0, err_timeout=0, hps_addr=0.
  - internal: cache invalid, state IDLE, timeout counter 0.
  - Reset mid-handshake drops hps_req immediately; no pix_valid is issued for the aborted request.
- hps_ack passes through a SYNC_STAGES synchronizer before use (ack_s). hps_data is captured only on the first cycle ack_s=1.
- busy = (state != IDLE) | pix_valid.
- A request is accepted only when pix_req=1 and busy=0. A pix_req arriving while busy=1 is dropped silently.
- Pixel lane = pix_addr[1:0]; pixel k occupies bits [8k+7:8k] (little-endian).
- Cache: one 32-bit word plus tag (pix_addr>>2) plus valid bit.
- States:
  - IDLE: on accept:
    - hit (valid, tag match, flush=0): next cycle pix_valid=1 with the cached byte; stay in IDLE.
    - miss: latch the address, drive hps_addr, go to REQ.
  - REQ: hps_req=1; timeout counter increments each cycle.
    - first cycle ack_s=1: capture hps_data into the cache, set the tag, set valid (unless a flush occurred during the fetch). Next edge: hps_req=0, pix_valid=1 with the addressed byte, go to REL.
    - counter reaches TIMEOUT_CYCLES-1 with ack_s=0: next edge: pix_valid=1, pix_data=0x00, err_timeout=1, hps_req=0, cache unchanged, go to REL.
  - REL: hps_req=0; wait for ack_s=0, then go to IDLE. The timeout counter is cleared on REQ entry.
- Latency:
  - hit: pix_valid one cycle after accept.
  - miss: hps_req rises one cycle after accept; pix_valid one cycle after ack_s is first seen high (HPS ack delay + SYNC_STAGES + 1).
  - throughput on consecutive hits: one pixel per 2 cycles.
- flush:
  - clears valid on the next edge.
  - flush in the same cycle as an accepted request: the request is treated as a miss.
  - flush during REQ or REL: the in-flight word is returned but not cached.
- hps_addr holds its value from REQ entry until the next miss is accepted.
- err_timeout is cleared only by reset.
- Pixel index beyond the image size: no range check; the word address is passed through.

Decomposition:
- Shared package:
  - state enum (IDLE, REQ, REL)
  - PIX_PER_WORD=4
  - IMG_W=160, IMG_H=120, IMG_PIXELS=19200
  - HPS word width 32, word address width 15
- Sub-module: sync_2ff (parameterised depth), used for hps_ack and reusable for the switch synchronisers.

Test Plan:
1. Reset:
   - Hold vga_reset=0 for 5 cycles.
   - Require all outputs 0; toggling hps_ack has no effect.
2. Miss:
   - pix_req with addr=5 (cache invalid). Require hps_req=1 and hps_addr=1.
   - HPS asserts ack 3 cycles later with data 0xDDCCBBAA. Require pix_valid with pix_data=0xBB, then hps_req=0.
   - Drop ack. Require busy=0 afterwards.
3. Hit:
   - After test 2, pix_req with addr=7. Require pix_valid next cycle with 0xDD and no hps_req edge.
   - Strobe addr=6 in the pix_valid cycle (busy=1). Require it to be ignored.
4. Flush:
   - Pulse flush, then pix_req with addr=4. Require a new handshake with hps_addr=1.
   - Also: flush during REQ, then request addr=4 again. Require a second handshake.
5. Timeout:
   - TIMEOUT_CYCLES=16, addr=100, HPS never acks.
   - Require hps_addr=25, pix_valid with 0x00 after 16 REQ cycles, err_timeout=1 held, and the next request re-fetches.
6. Reset mid-REQ:
   - Assert vga_reset=0 while hps_req=1. Require hps_req=0 asynchronously and no pix_valid.
   - After release, addr=7 misses.
